// File: rtl/rgb_to_ycbcr_pipe.sv
// rtl/rgb_to_ycbcr_pipe.sv - 3-stage full-range BT.601 RGB to YCbCr converter with frame controller
module rgb_to_ycbcr_pipe #(
    parameter logic [31:0] NUM_PIXELS = 32'd1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  R_in,
    input  logic [7:0]  G_in,
    input  logic [7:0]  B_in,
    output logic        in_ready,
    output logic [31:0] Y_O,
    output logic [31:0] Cb_O,
    output logic [31:0] Cr_O,
    output logic        out_valid,
    output logic [31:0] out_count,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // Coefficient order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B)
    localparam logic signed [17:0] K [9] = '{
        18'sd77,  18'sd150,  18'sd29,
        -18'sd43, -18'sd85,  18'sd128,
        18'sd128, -18'sd107, -18'sd21
    };

    state_t            state_q;
    logic [31:0]       acc_q;
    logic [31:0]       cnt_q;
    logic              v1_q, v2_q, v3_q;
    logic signed [17:0] p_q   [9];
    logic signed [17:0] sum_q [3];
    logic [7:0]        ycc_q [3];
    logic signed [17:0] px    [3];
    logic              accept;

    assign px[0]  = {10'd0, R_in};
    assign px[1]  = {10'd0, G_in};
    assign px[2]  = {10'd0, B_in};
    assign accept = in_valid && (state_q == S_RUN);

    function automatic logic [7:0] clamp8(input logic signed [17:0] v);
        if (v < 18'sd0)
            return 8'd0;
        else if (v > 18'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            if (v3_q)
                cnt_q <= cnt_q + 32'd1;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        acc_q   <= 32'd0;
                        cnt_q   <= 32'd0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        acc_q <= acc_q + 32'd1;
                        if (acc_q == NUM_PIXELS - 32'd1)
                            state_q <= S_DRAIN;
                    end
                end
                // S1/S2 empty means the final output is on the port now, so done lands next cycle
                S_DRAIN: begin
                    if (!v1_q && !v2_q)
                        state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            for (int i = 0; i < 9; i++)
                p_q[i] <= 18'sd0;
            for (int j = 0; j < 3; j++) begin
                sum_q[j] <= 18'sd0;
                ycc_q[j] <= 8'd0;
            end
        end else begin
            v1_q <= accept;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (accept)
                for (int i = 0; i < 9; i++)
                    p_q[i] <= px[i % 3] * K[i];
            if (v1_q)
                for (int j = 0; j < 3; j++)
                    sum_q[j] <= p_q[3*j] + p_q[3*j+1] + p_q[3*j+2] + 18'sd128;
            if (v2_q) begin
                ycc_q[0] <= clamp8(sum_q[0] >>> 8);
                ycc_q[1] <= clamp8((sum_q[1] >>> 8) + 18'sd128);
                ycc_q[2] <= clamp8((sum_q[2] >>> 8) + 18'sd128);
            end
        end
    end

    assign in_ready  = (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_valid = v3_q;
    assign out_count = cnt_q;
    assign Y_O       = {24'd0, ycc_q[0]};
    assign Cb_O      = {24'd0, ycc_q[1]};
    assign Cr_O      = {24'd0, ycc_q[2]};

endmodule
